pipe_stage_buf: RTL

Parametrised pipeline-stage register with a valid/ready handshake, optional two-entry skid buffer, synchronous flush-to-bubble and a stall-cycle counter. It generalises the fixed IF/ID stage register so that every stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB) can use one block with arbitrary payload width. It sits between two pipeline stages. Upstream offers a payload; downstream consumes it one cycle later at the earliest.

---
 rtl/pipe_stage_buf.sv | 117 +++++++++++
 1 files changed

// File: rtl/pipe_stage_buf.sv
// Generic pipeline stage register with valid/ready handshake,
// optional two-entry skid buffer, flush-to-bubble and stall counter.
module pipe_stage_buf #(
    parameter int               WIDTH  = 64,
    parameter logic [WIDTH-1:0] BUBBLE = '0,
    parameter bit               SKID   = 1'b1,
    parameter int               CNT_W  = 16
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             enable,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   main_q, main_d;
    logic [WIDTH-1:0]   skid_q, skid_d;
    logic [CNT_W-1:0]   stall_q, stall_d;
    logic               push, pop;

    // Handshake outputs; skid mode keeps out_ready off the in_ready path
    always_comb begin
        out_valid = enable & (state_q != EMPTY);
        if (SKID) begin
            in_ready = enable & ~flush & (state_q != TWO);
        end else begin
            in_ready = enable & ~flush & ((state_q == EMPTY) | out_ready);
        end
        push = in_valid & in_ready;
        pop  = out_valid & out_ready;
    end

    // Next-state and storage update: freeze, then flush, then push/pop
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (enable) begin
            if (flush) begin
                state_d = EMPTY;
                main_d  = BUBBLE;
            end else begin
                case (state_q)
                    EMPTY: begin
                        if (push) begin
                            main_d  = in_data;
                            state_d = ONE;
                        end
                    end
                    ONE: begin
                        if (push && pop) begin
                            main_d = in_data;
                        end else if (pop) begin
                            main_d  = BUBBLE;
                            state_d = EMPTY;
                        end else if (push && SKID) begin
                            skid_d  = in_data;
                            state_d = TWO;
                        end
                    end
                    TWO: begin
                        if (pop) begin
                            main_d  = skid_q;
                            state_d = ONE;
                        end
                    end
                    default: begin
                        main_d  = BUBBLE;
                        state_d = EMPTY;
                    end
                endcase
            end
        end
    end

    // Saturating count of cycles where a valid head is held back
    always_comb begin
        stall_d = stall_q;
        if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // State registers; reset empties the stage immediately
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= EMPTY;
            main_q  <= BUBBLE;
            skid_q  <= BUBBLE;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            stall_q <= stall_d;
        end
    end

    assign out_data  = main_q;
    assign occupancy = state_q;
    assign stall_cnt = stall_q;

endmodule
